// File: rtl/pgm_ctl.sv
// Run-control sequencer for the packet generator: decodes register accesses on
// the control-packet chain and sequences the reader flags through a run.
module pgm_ctl #(
  parameter string      PLATFORM = "Xilinx",
  parameter logic [7:0] LMID     = 8'd60
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_load_done,
  input  logic          rd_pkt_done,
  output logic          pgm_bypass_flag,
  output logic          pgm_sent_start_flag,
  output logic          pgm_sent_finish_flag,
  output logic          pgm_clr,
  output logic          pgm_busy,
  input  logic [133:0]  cin_ctl_data,
  input  logic          cin_ctl_data_wr,
  output logic          cout_ctl_ready,
  output logic [133:0]  cout_ctl_data,
  output logic          cout_ctl_data_wr,
  input  logic          cin_ctl_ready
);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_ARM  = 5'b00010,
    S_RUN  = 5'b00100,
    S_FIN  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  state_t       r_state;
  state_t       w_state_next;

  logic         r_bypass_en;
  logic [31:0]  r_pkt_target;
  logic [31:0]  r_cyc_limit;
  logic [31:0]  r_pkt_cnt;
  logic [31:0]  r_cyc_cnt;

  logic         r_bypass_flag;
  logic         r_start_flag;
  logic         r_finish_flag;
  logic         r_clr;
  logic         r_busy;
  logic [133:0] r_cout_data;
  logic         r_cout_wr;

  logic         w_hdr;
  logic         w_is_wr;
  logic         w_is_rd;
  logic [31:0]  w_addr;
  logic [31:0]  w_wdata;
  logic [31:0]  w_rdata;
  logic         w_start;
  logic         w_stop;
  logic         w_ctrl_wr;
  logic         w_bypass_en_next;
  logic         w_counting;
  logic [31:0]  w_pkt_inc;
  logic [31:0]  w_cyc_inc;
  logic [31:0]  w_pkt_upd;
  logic [31:0]  w_cyc_upd;
  logic         w_end_cond;
  logic         w_clr_cnt;

  // Only the first beat of a packet addressed to this module is decoded.
  assign w_hdr   = cin_ctl_data_wr && cin_ctl_ready &&
                   (cin_ctl_data[133:132] == 2'b01) &&
                   (cin_ctl_data[103:96] == LMID);
  assign w_is_wr = w_hdr && (cin_ctl_data[126:124] == 3'b010);
  assign w_is_rd = w_hdr && (cin_ctl_data[126:124] == 3'b001);
  assign w_addr  = cin_ctl_data[95:64];
  assign w_wdata = cin_ctl_data[31:0];

  assign w_ctrl_wr        = w_is_wr && (w_addr == 32'h0);
  assign w_start          = w_ctrl_wr && w_wdata[0];
  assign w_stop           = w_ctrl_wr && w_wdata[1];
  assign w_bypass_en_next = w_ctrl_wr ? w_wdata[2] : r_bypass_en;

  always_comb begin
    w_rdata = 32'hffff_ffff;
    case (w_addr)
      32'h0:   w_rdata = {29'd0, r_bypass_en, 2'b00};
      32'h1:   w_rdata = r_pkt_target;
      32'h2:   w_rdata = r_cyc_limit;
      32'h3:   w_rdata = {27'd0, r_state};
      32'h4:   w_rdata = r_pkt_cnt;
      32'h5:   w_rdata = r_cyc_cnt;
      default: w_rdata = 32'hffff_ffff;
    endcase
  end

  // Saturating increments; the two forms are equivalent, picked per vendor.
  generate
    if (PLATFORM == "Xilinx") begin : g_inc_xlnx
      assign w_pkt_inc = (&r_pkt_cnt) ? r_pkt_cnt : r_pkt_cnt + 32'd1;
      assign w_cyc_inc = (&r_cyc_cnt) ? r_cyc_cnt : r_cyc_cnt + 32'd1;
    end else begin : g_inc_generic
      logic [32:0] w_pkt_sum;
      logic [32:0] w_cyc_sum;
      assign w_pkt_sum = {1'b0, r_pkt_cnt} + 33'd1;
      assign w_cyc_sum = {1'b0, r_cyc_cnt} + 33'd1;
      assign w_pkt_inc = w_pkt_sum[32] ? r_pkt_cnt : w_pkt_sum[31:0];
      assign w_cyc_inc = w_cyc_sum[32] ? r_cyc_cnt : w_cyc_sum[31:0];
    end
  endgenerate

  assign w_counting = (r_state == S_RUN) || (r_state == S_FIN);
  assign w_pkt_upd  = (w_counting && rd_pkt_done) ? w_pkt_inc : r_pkt_cnt;
  assign w_cyc_upd  = w_counting ? w_cyc_inc : r_cyc_cnt;

  // End-of-run test uses the counts as they will be after this cycle.
  assign w_end_cond = w_stop ||
                      ((r_pkt_target != 32'd0) && (w_pkt_upd >= r_pkt_target - 32'd1)) ||
                      ((r_cyc_limit  != 32'd0) && (w_cyc_upd >= r_cyc_limit));

  always_comb begin
    w_state_next = r_state;
    w_clr_cnt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_clr_cnt    = 1'b1;
          w_state_next = wr_load_done ? S_RUN : S_ARM;
        end
      end
      S_ARM: begin
        if (w_stop)
          w_state_next = S_IDLE;
        else if (wr_load_done)
          w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_end_cond)
          w_state_next = S_FIN;
      end
      S_FIN: begin
        if (rd_pkt_done)
          w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pkt_cnt <= 32'd0;
      r_cyc_cnt <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_clr_cnt) begin
        r_pkt_cnt <= 32'd0;
        r_cyc_cnt <= 32'd0;
      end else begin
        r_pkt_cnt <= w_pkt_upd;
        r_cyc_cnt <= w_cyc_upd;
      end
    end
  end

  // Run parameters are frozen once a run has been started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bypass_en  <= 1'b1;
      r_pkt_target <= 32'd0;
      r_cyc_limit  <= 32'd0;
    end else begin
      r_bypass_en <= w_bypass_en_next;
      if (w_is_wr && (r_state == S_IDLE)) begin
        if (w_addr == 32'h1)
          r_pkt_target <= w_wdata;
        if (w_addr == 32'h2)
          r_cyc_limit <= w_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bypass_flag <= 1'b0;
      r_start_flag  <= 1'b0;
      r_finish_flag <= 1'b0;
      r_clr         <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_bypass_flag <= (w_state_next == S_IDLE) && w_bypass_en_next;
      r_start_flag  <= (w_state_next == S_RUN) || (w_state_next == S_FIN);
      r_finish_flag <= (w_state_next == S_FIN);
      r_clr         <= (w_state_next == S_DONE);
      r_busy        <= (w_state_next == S_ARM) || (w_state_next == S_RUN) ||
                       (w_state_next == S_FIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cout_data <= '0;
      r_cout_wr   <= 1'b0;
    end else begin
      r_cout_wr <= cin_ctl_data_wr;
      if (w_is_rd)
        r_cout_data <= {cin_ctl_data[133:128], 4'b1011, cin_ctl_data[123:32], w_rdata};
      else
        r_cout_data <= cin_ctl_data;
    end
  end

  assign pgm_bypass_flag      = r_bypass_flag;
  assign pgm_sent_start_flag  = r_start_flag;
  assign pgm_sent_finish_flag = r_finish_flag;
  assign pgm_clr              = r_clr;
  assign pgm_busy             = r_busy;
  assign cout_ctl_data        = r_cout_data;
  assign cout_ctl_data_wr     = r_cout_wr;
  assign cout_ctl_ready       = cin_ctl_ready;

endmodule

// File: tb/tb_pgm_ctl.sv
// Randomised bench for pgm_ctl: a cycle-level reference model feeds a
// scoreboard of expected control beats and flag values.
module tb_pgm_ctl;

  localparam logic [4:0] IDLE = 5'd1, ARM = 5'd2, RUN = 5'd4, FIN = 5'd8, DONE = 5'd16;
  localparam logic [7:0] MID  = 8'd60;

  typedef struct packed {
    logic [4:0]  st;
    logic [31:0] pkt;
    logic [31:0] cyc;
    logic [31:0] tgt;
    logic [31:0] lim;
    logic        byp;
    logic [4:0]  flags;
  } mstate_t;

  localparam mstate_t M_RST = '{st: IDLE, pkt: 32'd0, cyc: 32'd0, tgt: 32'd0,
                                lim: 32'd0, byp: 1'b1, flags: 5'd0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_load_done = 1'b0;
  logic         rd_pkt_done = 1'b0;
  logic [133:0] cin_ctl_data = '0;
  logic         cin_ctl_data_wr = 1'b0;
  logic         cin_ctl_ready = 1'b1;
  logic         pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag;
  logic         pgm_clr, pgm_busy, cout_ctl_ready, cout_ctl_data_wr;
  logic [133:0] cout_ctl_data;

  int checks = 0;
  int errors = 0;

  mstate_t      m = M_RST;
  logic         m_out_wr = 1'b0;
  logic [133:0] sb[$];

  pgm_ctl #(.PLATFORM("Xilinx"), .LMID(MID)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .wr_load_done         (wr_load_done),
    .rd_pkt_done          (rd_pkt_done),
    .pgm_bypass_flag      (pgm_bypass_flag),
    .pgm_sent_start_flag  (pgm_sent_start_flag),
    .pgm_sent_finish_flag (pgm_sent_finish_flag),
    .pgm_clr              (pgm_clr),
    .pgm_busy             (pgm_busy),
    .cin_ctl_data         (cin_ctl_data),
    .cin_ctl_data_wr      (cin_ctl_data_wr),
    .cout_ctl_ready       (cout_ctl_ready),
    .cout_ctl_data        (cout_ctl_data),
    .cout_ctl_data_wr     (cout_ctl_data_wr),
    .cin_ctl_ready        (cin_ctl_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call advances the run sequencer by one clock.
  function automatic mstate_t model_next(mstate_t s, logic [133:0] d, logic dwr, logic rdy,
                                         logic load, logic pd);
    mstate_t     n = s;
    logic        hdr, wrop, start, stop;
    logic [31:0] a, v;
    hdr   = dwr && rdy && (d[133:132] == 2'b01) && (d[103:96] == MID);
    wrop  = hdr && (d[126:124] == 3'b010);
    a     = d[95:64];
    v     = d[31:0];
    start = wrop && (a == 32'd0) && v[0];
    stop  = wrop && (a == 32'd0) && v[1];
    if (s.st == RUN || s.st == FIN) begin
      if (s.cyc != 32'hffff_ffff) n.cyc = s.cyc + 32'd1;
      if (pd && s.pkt != 32'hffff_ffff) n.pkt = s.pkt + 32'd1;
    end
    case (s.st)
      IDLE: if (start) begin
        n.pkt = 32'd0;
        n.cyc = 32'd0;
        n.st  = load ? RUN : ARM;
      end
      ARM:  if (stop) n.st = IDLE; else if (load) n.st = RUN;
      RUN:  if (stop ||
                (s.tgt != 0 && longint'(n.pkt) + 1 >= longint'(s.tgt)) ||
                (s.lim != 0 && longint'(n.cyc) >= longint'(s.lim)))
              n.st = FIN;
      FIN:  if (pd) n.st = DONE;
      default: n.st = IDLE;
    endcase
    if (wrop) begin
      if (a == 32'd0) n.byp = v[2];
      if (a == 32'd1 && s.st == IDLE) n.tgt = v;
      if (a == 32'd2 && s.st == IDLE) n.lim = v;
    end
    n.flags = {n.st == IDLE && n.byp, n.st == RUN || n.st == FIN, n.st == FIN,
               n.st == DONE, n.st == ARM || n.st == RUN || n.st == FIN};
    return n;
  endfunction

  function automatic logic [133:0] exp_beat(mstate_t s, logic [133:0] d, logic rdy);
    logic [133:0] e = d;
    logic [31:0]  rv;
    if (rdy && d[133:132] == 2'b01 && d[103:96] == MID && d[126:124] == 3'b001) begin
      case (d[95:64])
        32'd0:   rv = {29'd0, s.byp, 2'd0};
        32'd1:   rv = s.tgt;
        32'd2:   rv = s.lim;
        32'd3:   rv = {27'd0, s.st};
        32'd4:   rv = s.pkt;
        32'd5:   rv = s.cyc;
        default: rv = 32'hffff_ffff;
      endcase
      e[127:124] = 4'b1011;
      e[31:0]    = rv;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m        <= M_RST;
      m_out_wr <= 1'b0;
      sb.delete();
    end else begin
      if (cin_ctl_data_wr) sb.push_back(exp_beat(m, cin_ctl_data, cin_ctl_ready));
      m_out_wr <= cin_ctl_data_wr;
      m        <= model_next(m, cin_ctl_data, cin_ctl_data_wr, cin_ctl_ready,
                             wr_load_done, rd_pkt_done);
    end
  end

  // Monitor: compares every cycle, pops a scoreboard entry per output beat.
  always @(negedge clk) begin
    if (rst_n) begin
      check("flags", 134'({pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag,
                           pgm_clr, pgm_busy}), 134'(m.flags));
      check("ready", 134'(cout_ctl_ready), 134'(cin_ctl_ready));
      check("out_wr", 134'(cout_ctl_data_wr), 134'(m_out_wr));
      if (cout_ctl_data_wr) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ctl_beat got=%h want=none t=%0t", cout_ctl_data, $time);
        end else begin
          check("ctl_beat", cout_ctl_data, sb.pop_front());
        end
      end
    end
  end

  function automatic logic [133:0] mk(logic [2:0] op, logic [31:0] a, logic [31:0] v);
    logic [133:0] d = '0;
    d[133:132] = 2'b01;
    d[127]     = 1'($urandom_range(0, 1));
    d[126:124] = op;
    d[123:104] = 20'($urandom);
    d[103:96]  = MID;
    d[95:64]   = a;
    d[63:32]   = $urandom;
    d[31:0]    = v;
    return d;
  endfunction

  task automatic step(input logic [133:0] d, input logic dwr, input logic pd);
    @(posedge clk);
    #2;
    cin_ctl_data    = d;
    cin_ctl_data_wr = dwr;
    rd_pkt_done     = pd;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0, 1'b0);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] v);
    step(mk(3'b010, a, v), 1'b1, 1'b0);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    step(mk(3'b001, a, 32'h0), 1'b1, 1'b0);
  endtask

  task automatic rand_beat();
    logic [159:0] r;
    logic [133:0] d;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    d = r[133:0];
    d[103:96] = 8'd61;
    step(d, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state and bypass-flag rise
    @(negedge clk);
    check("rst_outs", 134'({pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag,
                            pgm_clr, pgm_busy, cout_ctl_data_wr}), 134'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("bypass_cycle0", 134'(pgm_bypass_flag), 134'(0));
    @(negedge clk);
    check("bypass_cycle1", 134'(pgm_bypass_flag), 134'(1));

    rd_reg(0);
    rd_reg(9);
    rd_reg(3);
    for (int i = 0; i < 4; i++) rand_beat();
    step(mk(3'b010, 32'd0, 32'd0) ^ {2'b11, 132'd0}, 1'b1, 1'b0);
    cin_ctl_ready = 1'b0;
    wr_reg(0, 32'h0);
    idle(1);
    cin_ctl_ready = 1'b1;
    wr_reg(0, 32'h0);
    idle(1);
    @(negedge clk);
    check("bypass_off", 134'(pgm_bypass_flag), 134'(0));
    wr_reg(0, 32'h4);

    // PKT_TARGET=3 with template loaded
    wr_load_done = 1'b1;
    wr_reg(1, 3);
    wr_reg(0, 32'h5);
    idle(1);
    @(negedge clk);
    check("start_plus1", 134'(pgm_sent_start_flag), 134'(1));
    idle(3);
    step('0, 1'b0, 1'b1);
    idle(2);
    step('0, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    check("finish_after_2nd", 134'(pgm_sent_finish_flag), 134'(1));
    idle(2);
    step('0, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    check("clr_done", 134'(pgm_clr), 134'(1));
    idle(1);
    @(negedge clk);
    check("clr_1cyc_bypass", 134'({pgm_clr, pgm_bypass_flag}), 134'(2'b01));
    rd_reg(4);
    rd_reg(3);

    // PKT_TARGET=1
    wr_reg(1, 1);
    wr_reg(0, 32'h5);
    idle(2);
    @(negedge clk);
    check("tgt1_fin", 134'(pgm_sent_finish_flag), 134'(1));
    step('0, 1'b0, 1'b1);
    idle(3);
    rd_reg(4);

    // CYC_LIMIT=100, unlimited packets
    wr_reg(1, 0);
    wr_reg(2, 100);
    wr_reg(0, 32'h5);
    idle(104);
    rd_reg(5);
    @(negedge clk);
    check("cyc_fin", 134'(pgm_sent_finish_flag), 134'(1));
    step('0, 1'b0, 1'b1);
    idle(3);
    rd_reg(5);
    rd_reg(2);

    // ARM path, then stop in ARM
    wr_reg(2, 0);
    wr_load_done = 1'b0;
    wr_reg(0, 32'h5);
    idle(2);
    rd_reg(3);
    wr_load_done = 1'b1;
    idle(1);
    @(negedge clk);
    check("arm_to_run", 134'(pgm_sent_start_flag), 134'(1));
    wr_reg(0, 32'h6);
    step('0, 1'b0, 1'b1);
    idle(3);
    wr_load_done = 1'b0;
    wr_reg(0, 32'h5);
    idle(2);
    wr_reg(0, 32'h6);
    idle(1);
    @(negedge clk);
    check("arm_stop", 134'({pgm_busy, pgm_sent_start_flag, pgm_bypass_flag}), 134'(3'b001));

    // Ignored writes during RUN, stop, then mid-run reset
    wr_load_done = 1'b1;
    wr_reg(0, 32'h5);
    idle(3);
    wr_reg(1, 5);
    rd_reg(1);
    wr_reg(0, 32'h5);
    idle(3);
    rd_reg(5);
    wr_reg(0, 32'h6);
    idle(1);
    @(negedge clk);
    check("stop_fin", 134'(pgm_sent_finish_flag), 134'(1));
    step('0, 1'b0, 1'b1);
    idle(3);
    wr_reg(0, 32'h5);
    idle(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst", 134'({pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag,
                              pgm_clr, pgm_busy}), 134'(0));
    idle(2);
    #1 rst_n = 1'b1;
    idle(2);
    rd_reg(3);

    // Randomised runs
    for (int r = 0; r < 25; r++) begin
      int c;
      wr_reg(1, $urandom_range(0, 5));
      wr_reg(2, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(10, 150));
      wr_load_done = 1'($urandom_range(0, 1));
      wr_reg(0, 32'h5);
      c = 0;
      while (c < 600 && !(c > 2 && m.st == IDLE)) begin
        int k;
        k = $urandom_range(0, 99);
        if (!wr_load_done && $urandom_range(0, 15) == 0) wr_load_done = 1'b1;
        if (k < 15)      step('0, 1'b0, 1'b1);
        else if (k < 25) step(mk(3'b001, $urandom_range(0, 7), 0), 1'b1, 1'($urandom_range(0, 1)));
        else if (k < 27) wr_reg(0, 32'h6);
        else if (k < 29) wr_reg(0, 32'h5);
        else if (k < 31) wr_reg($urandom_range(1, 2), $urandom_range(0, 9));
        else if (k < 34) rand_beat();
        else             idle(1);
        c++;
      end
      if (c >= 600) begin
        checks++;
        errors++;
        $display("FAIL run_timeout run=%0d got=busy want=idle", r);
        @(posedge clk);
        #2 rst_n = 1'b0;
        idle(1);
        #1 rst_n = 1'b1;
      end
      idle(2);
      rd_reg(4);
      rd_reg(5);
    end

    idle(3);
    check("sb_empty", 134'(sb.size()), 134'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pgm_ctl.md
# pgm_ctl

Run-control sequencer for the packet generator module (PGM). It sits beside the PGM write and read stages on the 134-bit control-packet chain and drives the reader's three mode flags: `pgm_bypass_flag`, `pgm_sent_start_flag` and `pgm_sent_finish_flag`. It counts generated packets and elapsed cycles, and ends a run on a packet-count target, a cycle limit or a software stop. It also issues the clear pulse that returns the reader from its finished state.

## Interface
- `PLATFORM`, "Xilinx", target vendor tag.
- `LMID`, 8'd60, own module ID; control packets with `[103:96]==LMID` are decoded.
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr_load_done` input 1: level; the packet template is stored in PGM RAM.
- `rd_pkt_done` input 1: one-cycle pulse per generated packet tail (reader `out_rd_valid_wr` with `out_rd_data[133:132]==2'b10`).
- `pgm_bypass_flag` output 1: pass normal traffic through the reader.
- `pgm_sent_start_flag` output 1: start generating.
- `pgm_sent_finish_flag` output 1: the next packet tail is the last one.
- `pgm_clr` output 1: one-cycle clear to the reader at the end of a run.
- `pgm_busy` output 1: a run is in progress (ARM, RUN or FIN).
- `cin_ctl_data` input 134: control packet beat in.
- `cin_ctl_data_wr` input 1: beat valid.
- `cout_ctl_ready` output 1: equals `cin_ctl_ready` (combinational).
- `cout_ctl_data` output 134: control packet beat out.
- `cout_ctl_data_wr` output 1: beat valid out.
- `cin_ctl_ready` input 1: downstream ready.

## Operation
- **Control decode** (first beat only: `[133:132]==01`, `wr`, `cin_ctl_ready`, MID match):
  - `[126:124]==3'b010` is a write; `[126:124]==3'b001` is a read. `[95:64]` is the address; `[31:0]` is the data.
  - Writes forward the beat unchanged.
  - Reads replace `[127:124]` with 4'b1011 and `[31:0]` with the register value. Unmapped addresses return 32'hffffffff.
  - All other beats, including the second beat, pass unchanged.
- **Register map:**
  - 0x0 CTRL (W): bit0 start (self-clearing request), bit1 stop (request), bit2 bypass_en (reset 1). Reads return `{29'b0, bypass_en, 2'b0}`.
  - 0x1 PKT_TARGET: 0 means unlimited. Reset 0.
  - 0x2 CYC_LIMIT: 0 means unlimited. Reset 0.
  - 0x3 STATUS (RO): `{27'b0, state[4:0]}`, one-hot, with IDLE=1, ARM=2, RUN=4, FIN=8, DONE=16.
  - 0x4 PKT_CNT (RO): saturates at 32'hffffffff.
  - 0x5 CYC_CNT (RO): saturates at 32'hffffffff.
  - Writes to 0x1 and 0x2 are ignored unless the state is IDLE.
- **State machine:**
  - IDLE: bypass flag = bypass_en. On start, clear PKT_CNT and CYC_CNT, then go to RUN if `wr_load_done==1`, else to ARM.
  - ARM: wait for `wr_load_done`, then go to RUN. A stop returns to IDLE.
  - RUN: CYC_CNT increments each cycle; PKT_CNT increments on `rd_pkt_done`. Go to FIN when any of these holds, using the post-update count:
    - stop requested;
    - PKT_TARGET≠0 and PKT_CNT ≥ PKT_TARGET−1;
    - CYC_LIMIT≠0 and CYC_CNT ≥ CYC_LIMIT.
  - FIN: counting continues. The next `rd_pkt_done` moves the block to DONE.
  - DONE: drives `pgm_clr` for one cycle, then returns to IDLE. The counters hold their values for readback.
- **Flag outputs** (all registered, decoded from the next state):
  - start flag = RUN or FIN.
  - finish flag = FIN.
  - bypass flag = IDLE and bypass_en.
  - busy = ARM, RUN or FIN.
- **Ignored inputs:** a start outside IDLE is ignored; a stop in FIN or DONE is ignored. An `rd_pkt_done` outside RUN and FIN is ignored.
- **Simultaneous events:** when stop and a count-limit condition occur together in RUN, the result is a single transition to FIN.
- **Reset:** asynchronous reset mid-run forces IDLE. All outputs reset to 0, all registers reset to 0 except bypass_en=1. `pgm_bypass_flag` rises in the first cycle after reset release.

## Timing
- Control path latency is 1 cycle, in to out.
- A written register value is effective in the cycle after the write beat.
- Start write with template loaded: `pgm_sent_start_flag` is high in cycle +1.
- From ARM: the start flag is high 1 cycle after `wr_load_done` rises.
- RUN→FIN takes 1 cycle after the qualifying event.
- FIN→DONE is entered in the cycle after the final `rd_pkt_done`. `pgm_clr` is high for exactly that 1 cycle. The bypass flag returns in the following cycle.
- Back-to-back control beats are accepted every cycle while `cin_ctl_ready` is high.

## Test plan
- Reset release → all outputs 0, then the bypass flag is 1 in cycle 1. A read of 0x0 returns 32'h4; a read of 0x9 returns 32'hffffffff with `[127:124]`=4'b1011.
- PKT_TARGET=3, load done, start, 3 `rd_pkt_done` pulses →
  - the finish flag rises 1 cycle after the 2nd pulse;
  - DONE follows the 3rd pulse, with `pgm_clr` high for 1 cycle;
  - PKT_CNT reads 3.
- PKT_TARGET=1 → FIN is entered 1 cycle after RUN. The first pulse ends the run; PKT_CNT=1.
- CYC_LIMIT=100, PKT_TARGET=0 → FIN when CYC_CNT=100. The run ends on the next pulse.
- Start with `wr_load_done=0` → ARM; STATUS reads 2. Raising the load flag gives RUN in the next cycle. A stop while in ARM returns to IDLE with no start flag.
- During RUN: a write PKT_TARGET=5 is ignored (readback still shows the old value), and a second start write is ignored. A stop write gives FIN, and the next pulse completes the run. Asserting `rst_n` low mid-run gives IDLE with all flags 0.
